// File: rtl/tpu_timer_pkg.sv
// Shared types for the multi-channel TPU timer.
// Channel FSM states and channel mode encodings.
package tpu_timer_pkg;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_ARMED,
    CH_FIRED
  } ch_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tpu_timer_multi_if.sv
// Register-side bundle of the multi-channel TPU timer.
// master drives configuration/pulses, slave is the timer.
interface tpu_timer_multi_if #(
  parameter int WIDTH   = 16,
  parameter int NCH     = 4,
  parameter int PRESC_W = 8,
  parameter int TIME_W  = 7
);

  logic                   EN;
  logic [PRESC_W-1:0]     PRESCALE;
  logic [NCH*WIDTH-1:0]   CH_CMP;
  logic [NCH-1:0]         CH_MODE;
  logic [NCH-1:0]         CH_ARM;
  logic [NCH-1:0]         TIMERINTMSK;
  logic [NCH-1:0]         INTCLR;
  logic [NCH-1:0]         INTPEND;
  logic                   TPUINT;
  logic [WIDTH-1:0]       CNT;
  logic [TIME_W-1:0]      TIME;

  modport master (
    output EN, PRESCALE, CH_CMP, CH_MODE,
    output CH_ARM, TIMERINTMSK, INTCLR,
    input  INTPEND, TPUINT, CNT, TIME
  );

  modport slave (
    input  EN, PRESCALE, CH_CMP, CH_MODE,
    input  CH_ARM, TIMERINTMSK, INTCLR,
    output INTPEND, TPUINT, CNT, TIME
  );

endinterface

// File: rtl/tpu_timer_channel.sv
// One compare channel: IDLE/ARMED/FIRED FSM plus sticky pending.
// Match is evaluated in the current state before an arm applies.
module tpu_timer_channel
  import tpu_timer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic match_i,
  input  logic mode_i,
  input  logic arm_i,
  input  logic mask_i,
  input  logic clr_i,
  output logic pend_o
);

  ch_state_t state_q, state_d;
  logic      pend_q, pend_d;
  logic      fire;

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    unique case (state_q)
      CH_ARMED: begin
        fire = match_i;
        if (match_i && mode_i == MODE_ONESHOT)
          state_d = CH_FIRED;
      end
      CH_IDLE, CH_FIRED: state_d = state_q;
      default: state_d = CH_IDLE;
    endcase
    if (arm_i)
      state_d = CH_ARMED;
  end

  // set beats clear when both land in one cycle
  always_comb begin
    pend_d = pend_q;
    if (fire && mask_i)
      pend_d = 1'b1;
    else if (clr_i)
      pend_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CH_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/tpu_timer_multi.sv
// Multi-channel TPU timer: shared prescaled counter feeding
// NCH compare channels, OR-ed into the TPU interrupt line.
module tpu_timer_multi
  import tpu_timer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NCH     = 4,
  parameter int PRESC_W = 8,
  parameter int TIME_W  = 7
) (
  input  logic SYS_CLK,
  input  logic RSTTPU_N,
  tpu_timer_multi_if.slave bus
);

  localparam logic [PRESC_W-1:0] P_ONE = 1;
  localparam logic [WIDTH-1:0]   C_ONE = 1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic [NCH-1:0]     match;
  logic [NCH-1:0]     pend;

  // >= so a lowered PRESCALE ticks on the next enabled cycle
  always_comb begin
    tick    = bus.EN && (presc_q >= bus.PRESCALE);
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (bus.EN)
      presc_d = tick ? '0 : presc_q + P_ONE;
    if (tick)
      cnt_d = cnt_q + C_ONE;
  end

  always_ff @(posedge SYS_CLK or negedge RSTTPU_N) begin
    if (!RSTTPU_N) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NCH; i++)
      match[i] = tick &&
        (cnt_q == bus.CH_CMP[i*WIDTH +: WIDTH]);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tpu_timer_channel u_ch (
      .clk_i   (SYS_CLK),
      .rst_ni  (RSTTPU_N),
      .match_i (match[g]),
      .mode_i  (bus.CH_MODE[g]),
      .arm_i   (bus.CH_ARM[g]),
      .mask_i  (bus.TIMERINTMSK[g]),
      .clr_i   (bus.INTCLR[g]),
      .pend_o  (pend[g])
    );
  end

  assign bus.INTPEND = pend;
  assign bus.TPUINT  = |pend;
  assign bus.CNT     = cnt_q;
  assign bus.TIME    = cnt_q[WIDTH-1 -: TIME_W];

endmodule
